// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter
// Shares the single VRAM write port among four pixel-writer requesters with
// round-robin arbitration. A built-in clear sequencer can take over the port
// and fill the whole VRAM with one colour. All outputs towards the VRAM are
// registered; req_ready is combinational so a requester learns of its grant
// in the same cycle it presents the write.

module vram_write_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 12,
  parameter int VRAM_DEPTH = 19200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                req_valid,
  output logic [3:0]                req_ready,
  input  logic [4*ADDR_WIDTH-1:0]   req_addr,
  input  logic [4*DATA_WIDTH-1:0]   req_data,
  input  logic                      clear_start,
  input  logic [DATA_WIDTH-1:0]     clear_color,
  output logic                      clear_busy,
  output logic                      vram_we,
  output logic [ADDR_WIDTH-1:0]     vram_addr,
  output logic [DATA_WIDTH-1:0]     vram_data
);

  // The clear counter carries one extra bit so a depth of exactly
  // 2**ADDR_WIDTH never wraps before the last-write compare.
  localparam int                CNT_W    = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(VRAM_DEPTH - 1);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Control state
  logic [0:0]             r_state;
  logic [1:0]             r_rr_ptr;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0]  r_color;

  // VRAM-facing output registers
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_data;

  // Arbitration and sequencing signals
  logic [1:0]             w_idx;
  logic [1:0]             w_winner;
  logic                   w_any;
  logic                   w_grant_en;
  logic                   w_xfer;
  logic                   w_start;
  logic                   w_last;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [ADDR_WIDTH-1:0]  w_win_addr;
  logic [DATA_WIDTH-1:0]  w_win_data;

  // Round-robin search: walk from r_rr_ptr downwards in priority so the
  // candidate closest to the pointer is the last (winning) assignment.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_rr_ptr + 2'(k);
      if (req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Select the winning requester's address and data.
  always_comb begin
    w_win_addr = req_addr[ADDR_WIDTH-1:0];
    w_win_data = req_data[DATA_WIDTH-1:0];
    case (w_winner)
      2'd0: begin
        w_win_addr = req_addr[0*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_data = req_data[0*DATA_WIDTH +: DATA_WIDTH];
      end
      2'd1: begin
        w_win_addr = req_addr[1*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_data = req_data[1*DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        w_win_addr = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_data = req_data[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: begin
        w_win_addr = req_addr[3*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_data = req_data[3*DATA_WIDTH +: DATA_WIDTH];
      end
    endcase
  end

  // Grants are only handed out in ARB, never under reset, and a clear
  // request in the same cycle takes priority over every requester.
  assign w_start    = (r_state == ST_ARB) && clear_start && !reset;
  assign w_grant_en = (r_state == ST_ARB) && !clear_start && !reset;
  assign req_ready  = (w_grant_en && w_any) ? (4'b0001 << w_winner) : 4'b0000;
  assign w_xfer     = |(req_valid & req_ready);

  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_last     = (r_cnt == LAST_CNT);

  // FSM, clear counter and captured fill colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ARB;
      r_cnt   <= '0;
      r_color <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_color <= clear_color;
          end
        end
        ST_CLEAR: begin
          r_cnt <= w_cnt_next;
          if (w_last) begin
            r_state <= ST_ARB;
          end
        end
        default: begin
          r_state <= ST_ARB;
        end
      endcase
    end
  end

  // Round-robin pointer moves past the winner on every accepted write;
  // a clear leaves it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= 2'd0;
    end else if (w_xfer) begin
      r_rr_ptr <= w_winner + 2'd1;
    end
  end

  // Registered write port. The clear's first write (address 0) is loaded on
  // the accepting edge so the strobe lines up with clear_busy for exactly
  // VRAM_DEPTH cycles. Address and data hold whenever no write is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_start) begin
            r_we   <= 1'b1;
            r_addr <= '0;
            r_data <= clear_color;
          end else if (w_xfer) begin
            r_we   <= 1'b1;
            r_addr <= w_win_addr;
            r_data <= w_win_data;
          end else begin
            r_we   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (w_last) begin
            r_we   <= 1'b0;
          end else begin
            r_we   <= 1'b1;
            r_addr <= w_cnt_next[ADDR_WIDTH-1:0];
            r_data <= r_color;
          end
        end
        default: begin
          r_we <= 1'b0;
        end
      endcase
    end
  end

  assign clear_busy = (r_state == ST_CLEAR);
  assign vram_we    = r_we;
  assign vram_addr  = r_addr;
  assign vram_data  = r_data;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Testbench for vram_write_arbiter: directed scenarios with literal
// expectations, followed by randomized traffic, all checked every cycle
// against a queue-based behavioural model.

module tb_vram_write_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 12;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_data;
  logic            clear_start;
  logic [DW-1:0]   clear_color;
  logic            clear_busy;
  logic            vram_we;
  logic [AW-1:0]   vram_addr;
  logic [DW-1:0]   vram_data;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  vram_write_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .VRAM_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_data   (vram_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: remaining clear addresses as a queue, a round-robin
  // pointer, and the write the VRAM port is expected to show this cycle.
  int            cq[$];
  int            m_ptr  = 0;
  logic [DW-1:0] m_col  = '0;
  logic          m_we   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            mw;
  int            cw;
  logic [3:0]    exp_rdy;

  function automatic int winner(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      cq.delete();
      m_ptr  = 0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else if (cq.size() != 0) begin
      void'(cq.pop_front());
      if (cq.size() != 0) begin
        m_we   = 1'b1;
        m_addr = AW'(cq[0]);
        m_data = m_col;
      end else begin
        m_we = 1'b0;
      end
    end else if (clear_start) begin
      for (int a = 0; a < DEPTH; a++) cq.push_back(a);
      m_col  = clear_color;
      m_we   = 1'b1;
      m_addr = '0;
      m_data = clear_color;
    end else begin
      mw = winner(req_valid, m_ptr);
      if (mw >= 0) begin
        m_we   = 1'b1;
        m_addr = req_addr[mw*AW +: AW];
        m_data = req_data[mw*DW +: DW];
        m_ptr  = (mw + 1) % 4;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      cw = winner(req_valid, m_ptr);
      if (reset || cq.size() != 0 || clear_start || cw < 0) exp_rdy = 4'b0000;
      else exp_rdy = 4'b0001 << cw;
      chk("model_ready", 32'(req_ready), 32'(exp_rdy));
      chk("model_busy",  32'(clear_busy), 32'(cq.size() != 0));
      chk("model_we",    32'(vram_we), 32'(m_we));
      chk("model_addr",  32'(vram_addr), 32'(m_addr));
      chk("model_data",  32'(vram_data), 32'(m_data));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 4'hF;
    req_addr    = '0;
    req_data    = '0;
    clear_start = 1'b0;
    clear_color = '0;
    cyc();
    cmp_en = 1'b1;
    cyc();

    // Reset state, with every requester valid
    at_neg();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we",    32'(vram_we), 32'h0);
    chk("rst_addr",  32'(vram_addr), 32'h0);
    chk("rst_data",  32'(vram_data), 32'h0);
    chk("rst_busy",  32'(clear_busy), 32'h0);

    // Single requester 2
    cyc();
    reset     = 1'b0;
    req_valid = 4'b0100;
    set_req(2, 15'h0100, 12'hF00);
    at_neg();
    chk("t1_ready", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_req(i, AW'(16'h0010 * i + 1), DW'(12'h100 + i));
    at_neg();
    chk("t1_we",   32'(vram_we), 32'h1);
    chk("t1_addr", 32'(vram_addr), 32'h0100);
    chk("t1_data", 32'(vram_data), 32'hF00);
    chk("t1_ptr3", 32'(req_ready), 32'b1000);

    // All four competing from reset: 0,1,2,3,0,...
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int g = 0; g < 8; g++) begin
      at_neg();
      chk("t2_grant", 32'(req_ready), 32'(1 << (g % 4)));
      if (g > 0) begin
        chk("t2_we",   32'(vram_we), 32'h1);
        chk("t2_addr", 32'(vram_addr), 32'(16'h0010 * ((g - 1) % 4) + 1));
      end
      cyc();
    end

    // Clear with a pending request; re-pulse of clear_start at write 3
    req_valid   = 4'b0010;
    clear_start = 1'b1;
    clear_color = 12'h0F0;
    at_neg();
    chk("t3_start_ready", 32'(req_ready), 32'h0);
    cyc();
    clear_color = 12'h555;
    for (int k = 0; k < DEPTH; k++) begin
      clear_start = (k == 3);
      at_neg();
      chk("t3_busy",  32'(clear_busy), 32'h1);
      chk("t3_we",    32'(vram_we), 32'h1);
      chk("t3_addr",  32'(vram_addr), 32'(k));
      chk("t3_data",  32'(vram_data), 32'h0F0);
      chk("t3_ready", 32'(req_ready), 32'h0);
      cyc();
    end
    clear_start = 1'b0;
    at_neg();
    chk("t3_busy_end",  32'(clear_busy), 32'h0);
    chk("t3_we_end",    32'(vram_we), 32'h0);
    chk("t3_ready_end", 32'(req_ready), 32'b0010);
    cyc();
    req_valid = 4'b0000;
    at_neg();
    chk("t3_post_we",   32'(vram_we), 32'h1);
    chk("t3_post_addr", 32'(vram_addr), 32'h0011);

    // Reset at clear write 4
    cyc();
    clear_start = 1'b1;
    clear_color = 12'hABC;
    cyc();
    clear_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) reset = 1'b1;
      at_neg();
      chk("t5_addr", 32'(vram_addr), 32'(k));
      cyc();
    end
    at_neg();
    chk("t5_we",   32'(vram_we), 32'h0);
    chk("t5_busy", 32'(clear_busy), 32'h0);
    cyc();
    reset     = 1'b0;
    req_valid = 4'hF;
    at_neg();
    chk("t5_ptr0", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = 4'b0000;
    at_neg();
    chk("t5_we_after", 32'(vram_we), 32'h1);
    chk("t5_addr_after", 32'(vram_addr), 32'h0001);

    // Sparse requests with idle hold
    cyc();
    req_valid = 4'b0010;
    set_req(1, 15'h0222, 12'h123);
    at_neg();
    chk("t6_ready1", 32'(req_ready), 32'b0010);
    cyc();
    req_valid = 4'b0000;
    at_neg();
    chk("t6_we1",   32'(vram_we), 32'h1);
    chk("t6_addr1", 32'(vram_addr), 32'h0222);
    cyc();
    at_neg();
    chk("t6_idle_we",   32'(vram_we), 32'h0);
    chk("t6_idle_addr", 32'(vram_addr), 32'h0222);
    chk("t6_idle_data", 32'(vram_data), 32'h123);
    cyc();
    req_valid = 4'b0001;
    set_req(0, 15'h0333, 12'hABC);
    at_neg();
    chk("t6_ready0", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = 4'b0000;
    at_neg();
    chk("t6_we0",   32'(vram_we), 32'h1);
    chk("t6_addr0", 32'(vram_addr), 32'h0333);
    chk("t6_data0", 32'(vram_data), 32'hABC);
    cyc();

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      clear_start = ($urandom_range(0, 59) == 0);
      clear_color = DW'($urandom);
      req_valid   = 4'($urandom);
      for (int i = 0; i < 4; i++) set_req(i, AW'($urandom), DW'($urandom));
      cyc();
    end
    reset       = 1'b0;
    clear_start = 1'b0;
    req_valid   = 4'b0000;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
